// File: rtl/cdc_tx_arbiter_if.sv
// rtl/cdc_tx_arbiter_if.sv - requester/CDC-side signal bundle for cdc_tx_arbiter (optional CDC_TX_ARBITER_STATS_EN adds grant_cnt_o)
interface cdc_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                  en_i;
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ*DW-1:0]    req_data_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [IDW+DW-1:0]     cdc_data_o;
    logic                  cdc_valid_o;
    logic                  busy_o;
`ifdef CDC_TX_ARBITER_STATS_EN
    logic [NREQ*16-1:0]    grant_cnt_o;

    // Producer/CDC side: drives requests, observes grants and issue pulses
    modport master (
        output en_i, req_valid_i, req_data_i,
        input  req_ready_o, cdc_data_o, cdc_valid_o, busy_o, grant_cnt_o
    );

    // Arbiter side
    modport slave (
        input  en_i, req_valid_i, req_data_i,
        output req_ready_o, cdc_data_o, cdc_valid_o, busy_o, grant_cnt_o
    );
`else
    // Producer/CDC side: drives requests, observes grants and issue pulses
    modport master (
        output en_i, req_valid_i, req_data_i,
        input  req_ready_o, cdc_data_o, cdc_valid_o, busy_o
    );

    // Arbiter side
    modport slave (
        input  en_i, req_valid_i, req_data_i,
        output req_ready_o, cdc_data_o, cdc_valid_o, busy_o
    );
`endif
endinterface

// File: rtl/cdc_tx_arbiter.sv
// rtl/cdc_tx_arbiter.sv - round-robin scheduler feeding one Fast2SlowCdc channel with hold-off (optional CDC_TX_ARBITER_STATS_EN)
module cdc_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int HOLDOFF = 16
) (
    input  logic           clk,
    input  logic           rst,
    cdc_tx_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    last;
    logic [IDW-1:0]    grant_idx;
    logic              grant_found;
    logic              grant_take;
    logic [CW-1:0]     hold_cnt;
    logic [NREQ-1:0]   ready;
    logic [IDW+DW-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic [IDW-1:0]    idx;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(last) + i) % NREQ);
            if (!grant_found && bus.req_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Grant only from IDLE; rst suppresses the strobe so a coincident reset wins
    always_comb begin
        grant_take = (state == IDLE) && bus.en_i && !rst && grant_found;
        ready      = '0;
        if (grant_take) begin
            ready[grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.cdc_data_o  = data_q;
    assign bus.cdc_valid_o = valid_q;
    assign bus.busy_o      = busy_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one ISSUE cycle, then HOLD until the counter reaches zero
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_take) state_nxt = ISSUE;
            ISSUE:   state_nxt = HOLD;
            HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, pointer and hold-off counter
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            last     <= IDW'(NREQ - 1);
            hold_cnt <= '0;
        end else begin
            valid_q <= grant_take;
            busy_q  <= (state_nxt != IDLE);
            if (grant_take) begin
                data_q <= {grant_idx, bus.req_data_i[int'(grant_idx)*DW +: DW]};
                last   <= grant_idx;
            end
            if (state == ISSUE) begin
                hold_cnt <= CW'(HOLDOFF - 1);
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

`ifdef CDC_TX_ARBITER_STATS_EN
    logic [15:0] grant_cnt [NREQ];

    // Per-requester saturating accepted-word counters
    always_ff @(posedge clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (rst) begin
                grant_cnt[k] <= '0;
            end else if (ready[k] && bus.req_valid_i[k] && grant_cnt[k] != 16'hFFFF) begin
                grant_cnt[k] <= grant_cnt[k] + 16'd1;
            end
        end
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_cnt_out
        assign bus.grant_cnt_o[k*16 +: 16] = grant_cnt[k];
    end
`endif
endmodule
